// File: rtl/pcode_pkg.sv
// rtl/pcode_pkg.sv - shared types and helpers for the priority code transmitter
// Purpose: FSM state encoding and the code-width derivation used by
//          priority_code_tx and pcode_prio_enc.
// Ports:   none (package).
package pcode_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pcode_state_t;

    // Width of a binary index into a req_w-bit vector (minimum 1 bit).
    function automatic int pcode_code_w(input int req_w);
        int w;
        w = 1;
        while ((1 << w) < req_w) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pcode_prio_enc.sv
// rtl/pcode_prio_enc.sv - combinational highest-set-bit encoder
// Purpose: returns the index of the highest set bit of vec, whether any bit
//          is set, and whether exactly one bit is set.
// Ports:   vec    in  REQ_W   vector to encode
//          code   out CODE_W  highest set index (0 when nothing set)
//          any    out 1       at least one bit set
//          onehot out 1       exactly one bit set
module pcode_prio_enc
    import pcode_pkg::*;
#(
    parameter int REQ_W  = 8,
    parameter int CODE_W = pcode_code_w(REQ_W)
) (
    input  logic [REQ_W-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic              any,
    output logic              onehot
);

    // Scan low to high so the last hit is the highest index. A bit only
    // counts when it compares equal to 1, so an unknown bit is "not set".
    // onehot goes true on the first hit and false on any later hit.
    always_comb begin
        code   = '0;
        any    = 1'b0;
        onehot = 1'b0;
        for (int i = 0; i < REQ_W; i++) begin
            if (vec[i] == 1'b1) begin
                code   = CODE_W'(i);
                onehot = !any;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_code_tx.sv
// rtl/priority_code_tx.sv - sequential priority encoder / code transmitter
// Purpose: accepts a request vector and emits the index of every set bit,
//          highest first, one code per code_valid/code_ready handshake.
//          Optional parity output enabled by macro PCODE_PARITY_EN.
// Ports:   clk, rst_n               clock, synchronous active-low reset
//          req_valid/req_ready      request vector handshake, req_vec data
//          code_valid/code_ready    code stream handshake
//          code, code_last          current index, final code of the vector
//          code_par                 even parity over {code_last, code}
//                                   (PCODE_PARITY_EN only)
//          busy                     a vector is being transmitted
module priority_code_tx
    import pcode_pkg::*;
#(
    parameter  int REQ_W  = 8,
    localparam int CODE_W = pcode_code_w(REQ_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REQ_W-1:0]  req_vec,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code,
    output logic              code_last,
`ifdef PCODE_PARITY_EN
    output logic              code_par,
`endif
    output logic              busy
);

    pcode_state_t       r_state;
    pcode_state_t       w_state_nxt;
    logic [REQ_W-1:0]   r_pending;
    logic [REQ_W-1:0]   w_pending_nxt;
    logic [CODE_W-1:0]  w_code;
    logic               w_any;
    logic               w_onehot;

    pcode_prio_enc #(
        .REQ_W  (REQ_W),
        .CODE_W (CODE_W)
    ) u_enc (
        .vec    (r_pending),
        .code   (w_code),
        .any    (w_any),
        .onehot (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        req_ready     = 1'b0;
        code_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                // An all-zero vector is consumed without producing a beat.
                if (req_valid && (req_vec != '0)) begin
                    w_pending_nxt = req_vec;
                    w_state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                code_valid = 1'b1;
                if (!w_any) begin
                    // Only unknown bits remain: nothing encodable, so leave
                    // rather than sit in SEND forever.
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (code_ready) begin
                    w_pending_nxt[w_code] = 1'b0;
                    if (w_onehot) begin
                        w_pending_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            default: begin
                w_pending_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Outputs derive only from registered pending, so they hold while the
    // consumer stalls and read 0 whenever the block is idle or in reset.
    assign code      = w_code;
    assign code_last = w_onehot;
    assign busy      = (r_state == ST_SEND);

`ifdef PCODE_PARITY_EN
    assign code_par = ^{w_onehot, w_code};
`endif

endmodule
